// File: rtl/layer_mac_responder_pkg.sv
// Shared parameters, FSM state encoding and arithmetic helpers for the
// time-multiplexed fully-connected layer responder.
package layer_mac_pkg;

    localparam int NEURON_NUM       = 5;
    localparam int INPUT_WIDTH      = 9;
    localparam int OUTPUT_WIDTH     = 10;
    localparam int WEIGHT_WIDTH     = 16;
    localparam int FRACTION_WIDTH   = 8;
    localparam int LAYER_ADDR_WIDTH = 2;
    localparam int LAYER_MAX        = 3;

    localparam int CNT_W  = $clog2(NEURON_NUM);
    localparam int WIDX_W = $clog2(NEURON_NUM * NEURON_NUM);

    // Wide enough for NEURON_NUM products of an OUTPUT_WIDTH operand and a weight.
    function automatic int acc_width(input int out_w, input int wt_w, input int n);
        return out_w + 1 + wt_w + $clog2(n);
    endfunction

    localparam int ACC_W = acc_width(OUTPUT_WIDTH, WEIGHT_WIDTH, NEURON_NUM);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        WRITE,
        DONE
    } state_t;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUTPUT_WIDTH) - 1);

    // Drop the fraction bits, then clamp into the unsigned output range.
    function automatic logic [OUTPUT_WIDTH-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> FRACTION_WIDTH;
        if (shifted[ACC_W-1]) begin
            return '0;
        end else if (shifted > OUT_MAX) begin
            return '1;
        end else begin
            return shifted[OUTPUT_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/layer_mac_responder_if.sv
// Start/valid handshake between the network sequencer (master) and the layer responder (slave).
interface layer_mac_responder_if;
    import layer_mac_pkg::*;

    logic                                          start;
    logic [LAYER_ADDR_WIDTH-1:0]                   layer_number;
    logic [NEURON_NUM*INPUT_WIDTH-1:0]             start_input;
    logic [NEURON_NUM*NEURON_NUM*WEIGHT_WIDTH-1:0] weights;
    logic [NEURON_NUM*OUTPUT_WIDTH-1:0]            fp_output;
    logic                                          fp_output_valid;
    logic                                          busy;
    logic                                          error;

    modport master (
        output start, layer_number, start_input, weights,
        input  fp_output, fp_output_valid, busy, error
    );

    modport slave (
        input  start, layer_number, start_input, weights,
        output fp_output, fp_output_valid, busy, error
    );

endinterface

// File: rtl/layer_mac_responder_mac_unit.sv
// Signed multiply-accumulate: unsigned operand times signed weight, with
// synchronous clear taking priority over enable.
module mac_unit
    import layer_mac_pkg::*;
#(
    parameter int A_W      = OUTPUT_WIDTH,
    parameter int W_W      = WEIGHT_WIDTH,
    parameter int ACC_BITS = ACC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       enable,
    input  logic [A_W-1:0]             a,
    input  logic signed [W_W-1:0]      w,
    output logic signed [ACC_BITS-1:0] acc
);

    localparam int PROD_W = A_W + W_W + 1;

    logic signed [A_W:0]        a_signed;
    logic signed [PROD_W-1:0]   product;

    assign a_signed = {1'b0, a};
    assign product  = PROD_W'(a_signed) * PROD_W'(w);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACC_BITS'(product);
        end
    end

endmodule

// File: rtl/layer_mac_responder.sv
// Evaluates one fully-connected layer per start pulse using a single MAC,
// feeding its own previous output back as the operand for layers above 0.
module layer_mac_responder
    import layer_mac_pkg::*;
(
    input logic                clk,
    input logic                rst,
    layer_mac_responder_if.slave bus
);

    localparam logic [WIDX_W-1:0] ROW_STRIDE = WIDX_W'(NEURON_NUM);

    state_t                         state, state_next;
    logic [LAYER_ADDR_WIDTH-1:0]    layer_q;
    logic [CNT_W-1:0]               i_q, j_q;
    logic [OUTPUT_WIDTH-1:0]        operand    [NEURON_NUM];
    logic [OUTPUT_WIDTH-1:0]        result_buf [NEURON_NUM];
    logic [OUTPUT_WIDTH-1:0]        fp_q       [NEURON_NUM];
    logic signed [WEIGHT_WIDTH-1:0] w_cell     [NEURON_NUM*NEURON_NUM];
    logic [WIDX_W-1:0]              w_idx;
    logic signed [ACC_W-1:0]        acc;
    logic [OUTPUT_WIDTH-1:0]        sat_value;
    logic                           layer_ok, accept, reject;
    logic                           last_i, last_j;
    logic                           mac_clear, mac_en;
    logic                           error_q;

    assign layer_ok  = bus.layer_number < LAYER_ADDR_WIDTH'(LAYER_MAX);
    assign accept    = (state == IDLE) && bus.start && layer_ok;
    assign reject    = (state == IDLE) && bus.start && !layer_ok;
    assign last_i    = (i_q == CNT_W'(NEURON_NUM - 1));
    assign last_j    = (j_q == CNT_W'(NEURON_NUM - 1));
    assign w_idx     = WIDX_W'(i_q) * ROW_STRIDE + WIDX_W'(j_q);
    assign sat_value = sat_shift(acc);

    for (genvar k = 0; k < NEURON_NUM * NEURON_NUM; k++) begin : g_weight
        assign w_cell[k] = bus.weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    for (genvar k = 0; k < NEURON_NUM; k++) begin : g_output
        assign bus.fp_output[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = fp_q[k];
    end

    assign bus.fp_output_valid = (state == DONE);
    assign bus.busy            = (state == LOAD) || (state == MAC) || (state == WRITE);
    assign bus.error           = error_q;

    mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .enable (mac_en),
        .a      (operand[j_q]),
        .w      (w_cell[w_idx]),
        .acc    (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator is cleared on entry to every neuron so MAC always starts from zero.
    always_comb begin
        state_next = state;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                mac_clear  = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_j) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mac_clear  = 1'b1;
                state_next = last_i ? DONE : MAC;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The final neuron's result is merged straight into fp_q so the output
    // register already holds the whole layer during the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            error_q <= 1'b0;
            for (int k = 0; k < NEURON_NUM; k++) begin
                operand[k]    <= '0;
                result_buf[k] <= '0;
                fp_q[k]       <= '0;
            end
        end else begin
            error_q <= reject;
            if (accept) begin
                layer_q <= bus.layer_number;
            end
            case (state)
                LOAD: begin
                    i_q <= '0;
                    j_q <= '0;
                    for (int k = 0; k < NEURON_NUM; k++) begin
                        operand[k] <= (layer_q == '0)
                            ? OUTPUT_WIDTH'(bus.start_input[k*INPUT_WIDTH +: INPUT_WIDTH])
                            : fp_q[k];
                    end
                end
                MAC: begin
                    j_q <= last_j ? '0 : j_q + CNT_W'(1);
                end
                WRITE: begin
                    result_buf[i_q] <= sat_value;
                    if (last_i) begin
                        for (int k = 0; k < NEURON_NUM; k++) begin
                            fp_q[k] <= (CNT_W'(k) == i_q) ? sat_value : result_buf[k];
                        end
                    end else begin
                        i_q <= i_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac_responder.sv
// Directed bench for layer_mac_responder: one task per scenario, inline checks.
module tb_layer_mac_responder;
    import layer_mac_pkg::*;

    localparam int OUT_BITS = NEURON_NUM * OUTPUT_WIDTH;
    localparam int IN_BITS  = NEURON_NUM * INPUT_WIDTH;
    localparam int W_BITS   = NEURON_NUM * NEURON_NUM * WEIGHT_WIDTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    layer_mac_responder_if bus();

    layer_mac_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int wt [NEURON_NUM][NEURON_NUM];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_weights();
        logic [W_BITS-1:0] v;
        v = '0;
        for (int i = 0; i < NEURON_NUM; i++) begin
            for (int j = 0; j < NEURON_NUM; j++) begin
                v[(i*NEURON_NUM+j)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(wt[i][j]);
            end
        end
        bus.weights = v;
    endtask

    task automatic set_identity();
        for (int i = 0; i < NEURON_NUM; i++) begin
            for (int j = 0; j < NEURON_NUM; j++) begin
                wt[i][j] = (i == j) ? 256 : 0;
            end
        end
        apply_weights();
    endtask

    task automatic set_all(input int value);
        for (int i = 0; i < NEURON_NUM; i++) begin
            for (int j = 0; j < NEURON_NUM; j++) begin
                wt[i][j] = value;
            end
        end
        apply_weights();
    endtask

    task automatic apply_inputs(input int c [NEURON_NUM]);
        logic [IN_BITS-1:0] v;
        v = '0;
        for (int k = 0; k < NEURON_NUM; k++) begin
            v[k*INPUT_WIDTH +: INPUT_WIDTH] = INPUT_WIDTH'(c[k]);
        end
        bus.start_input = v;
    endtask

    function automatic logic [OUT_BITS-1:0] pack_out(input int v [NEURON_NUM]);
        logic [OUT_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < NEURON_NUM; k++) begin
            r[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = OUTPUT_WIDTH'(v[k]);
        end
        return r;
    endfunction

    // Integer reference: weighted sum, arithmetic shift, clamp to 0..1023.
    task automatic model_layer(input int a [NEURON_NUM], output int r [NEURON_NUM]);
        int sum;
        int s;
        for (int i = 0; i < NEURON_NUM; i++) begin
            sum = 0;
            for (int j = 0; j < NEURON_NUM; j++) begin
                sum += wt[i][j] * a[j];
            end
            s = sum >>> FRACTION_WIDTH;
            r[i] = (s < 0) ? 0 : ((s > 1023) ? 1023 : s);
        end
    endtask

    // Issues start during the current cycle and returns in the valid cycle.
    task automatic do_pass(input int layer, input int inject_cycle,
                           output int valid_cycle, output int busy_bad, output int err_seen);
        bus.layer_number = LAYER_ADDR_WIDTH'(layer);
        bus.start        = 1'b1;
        tick();
        bus.start   = 1'b0;
        valid_cycle = -1;
        busy_bad    = 0;
        err_seen    = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            bus.start = (cyc == inject_cycle);
            if (bus.error === 1'b1) err_seen++;
            if (bus.fp_output_valid === 1'b1) begin
                valid_cycle = cyc;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if (bus.fp_output !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fp_output: got %h expected 0", bus.fp_output);
        end
        tests_run++;
        if (bus.fp_output_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus.fp_output_valid);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        end
        tests_run++;
        if (bus.error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_error: got %b expected 0", bus.error);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        int c [NEURON_NUM];
        int vc, bb, es;
        set_identity();
        c = '{10, 20, 30, 40, 50};
        apply_inputs(c);
        do_pass(0, -1, vc, bb, es);
        tests_run++;
        if (vc !== 32) begin
            tests_failed++;
            $display("[TB] FAIL identity_latency: got %0d expected 32", vc);
        end
        tests_run++;
        if (bb !== 0) begin
            tests_failed++;
            $display("[TB] FAIL identity_busy_window: got %0d low cycles expected 0", bb);
        end
        tests_run++;
        if (bus.fp_output !== pack_out(c)) begin
            tests_failed++;
            $display("[TB] FAIL identity_value: got %h expected %h", bus.fp_output, pack_out(c));
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL identity_busy_at_valid: got %b expected 0", bus.busy);
        end
        tick();
        tests_run++;
        if (bus.fp_output_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL identity_valid_pulse: got %b expected 0", bus.fp_output_valid);
        end
        tests_run++;
        if (bus.fp_output !== pack_out(c)) begin
            tests_failed++;
            $display("[TB] FAIL identity_hold: got %h expected %h", bus.fp_output, pack_out(c));
        end
    endtask

    task automatic test_feedback();
        int e [NEURON_NUM];
        int vc, bb, es;
        set_all(128);
        e = '{75, 75, 75, 75, 75};
        do_pass(1, -1, vc, bb, es);
        tests_run++;
        if (vc !== 32) begin
            tests_failed++;
            $display("[TB] FAIL feedback_latency: got %0d expected 32", vc);
        end
        tests_run++;
        if (bus.fp_output !== pack_out(e)) begin
            tests_failed++;
            $display("[TB] FAIL feedback_value: got %h expected %h", bus.fp_output, pack_out(e));
        end
        tick();
    endtask

    task automatic test_saturation();
        int c [NEURON_NUM];
        int e [NEURON_NUM];
        int vc, bb, es;
        set_all(-256);
        c = '{10, 20, 30, 40, 50};
        apply_inputs(c);
        e = '{0, 0, 0, 0, 0};
        do_pass(0, -1, vc, bb, es);
        tests_run++;
        if (bus.fp_output !== pack_out(e)) begin
            tests_failed++;
            $display("[TB] FAIL sat_negative: got %h expected %h", bus.fp_output, pack_out(e));
        end
        tick();
        set_all(32767);
        c = '{511, 511, 511, 511, 511};
        apply_inputs(c);
        e = '{1023, 1023, 1023, 1023, 1023};
        do_pass(0, -1, vc, bb, es);
        tests_run++;
        if (bus.fp_output !== pack_out(e)) begin
            tests_failed++;
            $display("[TB] FAIL sat_positive: got %h expected %h", bus.fp_output, pack_out(e));
        end
        tick();
    endtask

    task automatic test_protocol();
        int c [NEURON_NUM];
        int vc, bb, es, nv, nb;
        set_identity();
        c = '{1, 2, 3, 4, 5};
        apply_inputs(c);
        do_pass(0, 5, vc, bb, es);
        tests_run++;
        if (vc !== 32) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_latency: got %0d expected 32", vc);
        end
        tests_run++;
        if (es !== 0) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_error: got %0d error cycles expected 0", es);
        end
        tests_run++;
        if (bus.fp_output !== pack_out(c)) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_value: got %h expected %h", bus.fp_output, pack_out(c));
        end
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.fp_output_valid === 1'b1) nv++;
        end
        tests_run++;
        if (nv !== 0) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_extra_valid: got %0d expected 0", nv);
        end
        bus.layer_number = 2'd3;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tests_run++;
        if (bus.error !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bad_layer_error: got %b expected 1", bus.error);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bad_layer_busy: got %b expected 0", bus.busy);
        end
        tick();
        tests_run++;
        if (bus.error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bad_layer_error_pulse: got %b expected 0", bus.error);
        end
        nv = 0;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.fp_output_valid === 1'b1) nv++;
            if (bus.busy !== 1'b0) nb++;
            tick();
        end
        tests_run++;
        if (nv !== 0 || nb !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bad_layer_activity: got %0d valid %0d busy cycles expected 0 0", nv, nb);
        end
        tests_run++;
        if (bus.fp_output !== pack_out(c)) begin
            tests_failed++;
            $display("[TB] FAIL bad_layer_hold: got %h expected %h", bus.fp_output, pack_out(c));
        end
    endtask

    task automatic test_reset_mid();
        int c [NEURON_NUM];
        int z [NEURON_NUM];
        int vc, bb, es, nv;
        set_identity();
        c = '{7, 8, 9, 10, 11};
        z = '{0, 0, 0, 0, 0};
        apply_inputs(c);
        bus.layer_number = 2'd0;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 12; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.fp_output !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_fp_output: got %h expected 0", bus.fp_output);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy);
        end
        tick();
        tick();
        rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.fp_output_valid === 1'b1 || bus.error === 1'b1) nv++;
            tick();
        end
        tests_run++;
        if (nv !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pulses: got %0d expected 0", nv);
        end
        do_pass(1, -1, vc, bb, es);
        tests_run++;
        if (bus.fp_output !== pack_out(z)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_feedback_cleared: got %h expected %h", bus.fp_output, pack_out(z));
        end
        tick();
        do_pass(0, -1, vc, bb, es);
        tests_run++;
        if (vc !== 32) begin
            tests_failed++;
            $display("[TB] FAIL midreset_restart_latency: got %0d expected 32", vc);
        end
        tests_run++;
        if (bus.fp_output !== pack_out(c)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_restart_value: got %h expected %h", bus.fp_output, pack_out(c));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int a [NEURON_NUM];
        int r [NEURON_NUM];
        int vc, bb, es;
        for (int i = 0; i < NEURON_NUM; i++) begin
            for (int j = 0; j < NEURON_NUM; j++) begin
                if (i == j)                       wt[i][j] = 200;
                else if (j == (i + 1) % NEURON_NUM) wt[i][j] = 60;
                else                              wt[i][j] = -20;
            end
        end
        apply_weights();
        a = '{100, 200, 300, 400, 500};
        apply_inputs(a);
        for (int l = 0; l < 3; l++) begin
            model_layer(a, r);
            if (l > 0) tick();
            do_pass(l, -1, vc, bb, es);
            tests_run++;
            if (vc !== 32) begin
                tests_failed++;
                $display("[TB] FAIL b2b_latency_layer%0d: got %0d expected 32", l, vc);
            end
            tests_run++;
            if (bus.fp_output !== pack_out(r)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_value_layer%0d: got %h expected %h", l, bus.fp_output, pack_out(r));
            end
            a = r;
        end
        tick();
    endtask

    initial begin
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.layer_number = '0;
        bus.start_input  = '0;
        bus.weights      = '0;
        test_reset();
        test_identity();
        test_feedback();
        test_saturation();
        test_protocol();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
